fp7_alu_exponent_compare_stage: RTL

- Front end of the fp7 ALU operand path; feeds control to the select stage.
- Takes the same operand pair that enters the select stage's operand delay line and compares their exponents.
- Produces i_exponent_big_a / select_data exactly aligned with the select stage's 4-deep operand delay, so both blocks are driven from one operand source with no extra glue.
- Also provides a valid flag, the absolute exponent difference for the downstream alignment shifter, and a saturating count of negligible-operand events.

---
 rtl/fp7_alu_exponent_compare_stage_pkg.sv | 28 ++
 rtl/fp7_alu_exponent_compare_stage_if.sv | 34 +++
 rtl/fp7_alu_exponent_compare_stage_sat_counter.sv | 39 +++
 rtl/fp7_alu_exponent_compare_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fp7_alu_exponent_compare_stage_pkg.sv
// Shared constants and helpers for the fp7 ALU operand path.
// Field positions below describe the default 32-bit packing
// {sign, exponent[8], mantissa[23]}; parameterised blocks derive their own
// positions from the same formulas.
package fp7_alu_pkg;

  // Default field widths of the fp7 operand container
  localparam int FP7_ACCUM_DATA_WIDTH = 32;
  localparam int FP7_EXP_W            = 8;
  localparam int FP7_MAN_W            = 23;
  localparam int FP7_GUARD_BITS       = 1;

  // Field-extraction positions inside the operand word
  localparam int EXP_LSB  = FP7_MAN_W;
  localparam int EXP_MSB  = FP7_MAN_W + FP7_EXP_W - 1;
  localparam int SIGN_BIT = FP7_ACCUM_DATA_WIDTH - 1;

  // Depth of the operand delay line in the select stage; the exponent
  // compare pipeline must have exactly this many register stages
  localparam int FP7_ALU_PIPE_DEPTH = 4;

  // Largest exponent gap for which the smaller operand can still influence
  // the aligned sum (mantissa bits plus guard positions)
  function automatic int fp7SelectThreshold(input int manW, input int guardBits);
    return manW + guardBits;
  endfunction

endpackage

// File: rtl/fp7_alu_exponent_compare_stage_if.sv
// Operand/control bundle between the fp7 operand source and the exponent
// compare stage. The master drives operands, the slave returns control.
interface fp7_alu_exponent_compare_stage_if #(
  parameter int ACCUM_DATA_WIDTH = 32,
  parameter int EXP_W            = 8,
  parameter int CNT_W            = 16
);

  logic                        valid_i;
  logic                        alu_op_i;
  logic [ACCUM_DATA_WIDTH-1:0] alu_data_a_i;
  logic [ACCUM_DATA_WIDTH-1:0] alu_data_b_i;
  logic                        cnt_clear_i;

  logic                        valid_o;
  logic                        alu_op_o;
  logic                        exponent_big_a_o;
  logic                        select_data_o;
  logic [EXP_W-1:0]            exp_diff_o;
  logic [CNT_W-1:0]            negligible_cnt_o;

  modport master (
    output valid_i, alu_op_i, alu_data_a_i, alu_data_b_i, cnt_clear_i,
    input  valid_o, alu_op_o, exponent_big_a_o, select_data_o, exp_diff_o,
           negligible_cnt_o
  );

  modport slave (
    input  valid_i, alu_op_i, alu_data_a_i, alu_data_b_i, cnt_clear_i,
    output valid_o, alu_op_o, exponent_big_a_o, select_data_o, exp_diff_o,
           negligible_cnt_o
  );

endinterface

// File: rtl/fp7_alu_exponent_compare_stage_sat_counter.sv
// Saturating event counter with synchronous clear. Clear wins over
// increment; once all-ones is reached the count holds until cleared.
module fp7_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear first, then increment unless already saturated
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fp7_alu_exponent_compare_stage.sv
// Exponent compare stage of the fp7 ALU operand path. Compares operand
// magnitudes and produces the big-operand / select control for the select
// stage, cycle-aligned with its 4-deep operand delay line, plus the absolute
// exponent gap for the alignment shifter and a count of negligible-operand
// events.
module fp7_alu_exponent_compare_stage
  import fp7_alu_pkg::*;
#(
  parameter int ACCUM_DATA_WIDTH = 32,
  parameter int EXP_W            = 8,
  parameter int MAN_W            = 23,
  parameter int GUARD_BITS       = 1,
  parameter int CNT_W            = 16
) (
  input logic clk,
  input logic rst,
  fp7_alu_exponent_compare_stage_if.slave bus
);

  localparam int ExpLsb  = MAN_W;
  localparam int ExpMsb  = MAN_W + EXP_W - 1;
  localparam int SignBit = ACCUM_DATA_WIDTH - 1;

  // Threshold widened by one bit so the compare against the gap is unsigned
  localparam logic [EXP_W:0] SelThresh =
    (EXP_W+1)'(fp7SelectThreshold(MAN_W, GUARD_BITS));

  // Stages S0..S2 carry valid/op; S3 is the output register itself
  localparam int CtlDepth = FP7_ALU_PIPE_DEPTH - 1;

  // Sign bits take no part in a magnitude compare
  logic unusedSigns;
  assign unusedSigns = bus.alu_data_a_i[SignBit] ^ bus.alu_data_b_i[SignBit];

  // Control pipe (valid, alu_op) for S0..S2
  logic [CtlDepth-1:0] validPipe_q;
  logic [CtlDepth-1:0] opPipe_q;

  // S0 field registers
  logic [EXP_W-1:0] expA_q;
  logic [EXP_W-1:0] expB_q;
  logic [MAN_W-1:0] manA_q;
  logic [MAN_W-1:0] manB_q;

  // S1 compare results
  logic [EXP_W:0]   diff_q;
  logic [EXP_W:0]   diff_d;
  logic             eqExp_q;
  logic             manGe_q;

  // S2 decision
  logic             bigA_q;
  logic             bigA_d;
  logic [EXP_W-1:0] absd_q;
  logic [EXP_W-1:0] absd_d;

  // S3 outputs
  logic             valid_q;
  logic             aluOp_q;
  logic             expBigA_q;
  logic             selData_q;
  logic             selData_d;
  logic [EXP_W-1:0] expDiff_q;

  logic             negligibleInc;

  // Valid and op travel alongside the data with no enable, so invalid slots
  // still advance and simply come out with valid low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validPipe_q <= '0;
      opPipe_q    <= '0;
    end else begin
      validPipe_q <= {validPipe_q[CtlDepth-2:0], bus.valid_i};
      opPipe_q    <= {opPipe_q[CtlDepth-2:0], bus.alu_op_i};
    end
  end

  // S0: capture the exponent and mantissa fields of both operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expA_q <= '0;
      expB_q <= '0;
      manA_q <= '0;
      manB_q <= '0;
    end else begin
      expA_q <= bus.alu_data_a_i[ExpMsb:ExpLsb];
      expB_q <= bus.alu_data_b_i[ExpMsb:ExpLsb];
      manA_q <= bus.alu_data_a_i[MAN_W-1:0];
      manB_q <= bus.alu_data_b_i[MAN_W-1:0];
    end
  end

  // Signed exponent difference; the extra MSB is the "B bigger" flag
  always_comb begin
    diff_d = {1'b0, expA_q} - {1'b0, expB_q};
  end

  // S1: register the difference and the tie-break inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q  <= '0;
      eqExp_q <= 1'b0;
      manGe_q <= 1'b0;
    end else begin
      diff_q  <= diff_d;
      eqExp_q <= (expA_q == expB_q);
      manGe_q <= (manA_q >= manB_q);
    end
  end

  // A wins when its exponent is larger, or on equal exponents when its
  // mantissa is not smaller (exact ties resolve to A); the gap magnitude
  // always fits EXP_W bits because both exponents are unsigned EXP_W fields
  always_comb begin
    bigA_d = ~diff_q[EXP_W] & (~eqExp_q | manGe_q);
    absd_d = diff_q[EXP_W] ? EXP_W'(-diff_q) : diff_q[EXP_W-1:0];
  end

  // S2: register the decision and the gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bigA_q <= 1'b0;
      absd_q <= '0;
    end else begin
      bigA_q <= bigA_d;
      absd_q <= absd_d;
    end
  end

  // The smaller operand still matters only while the gap fits in the
  // mantissa plus guard positions
  always_comb begin
    selData_d = ({1'b0, absd_q} <= SelThresh);
  end

  // S3: output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      aluOp_q   <= 1'b0;
      expBigA_q <= 1'b0;
      selData_q <= 1'b0;
      expDiff_q <= '0;
    end else begin
      valid_q   <= validPipe_q[CtlDepth-1];
      aluOp_q   <= opPipe_q[CtlDepth-1];
      expBigA_q <= bigA_q;
      selData_q <= selData_d;
      expDiff_q <= absd_q;
    end
  end

  // Count the result being registered into S3 this cycle when it is a valid
  // add/compare whose smaller operand vanishes
  assign negligibleInc = validPipe_q[CtlDepth-1] & opPipe_q[CtlDepth-1] & ~selData_d;

  fp7_sat_counter #(
    .CNT_W (CNT_W)
  ) u_negligible_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.cnt_clear_i),
    .inc_i   (negligibleInc),
    .count_o (bus.negligible_cnt_o)
  );

  assign bus.valid_o          = valid_q;
  assign bus.alu_op_o         = aluOp_q;
  assign bus.exponent_big_a_o = expBigA_q;
  assign bus.select_data_o    = selData_q;
  assign bus.exp_diff_o       = expDiff_q;

endmodule
